// File: rtl/scratchpad_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_responder_if
// Description : Kernel-side memory request bus between the accelerator wrapper
//               (master) and the scratchpad responder (slave).
//               mem_base                    byte address of scratchpad word 0
//               read_enable/read_addr       one-cycle read request
//               write_enable/write_addr/
//               write_data                  one-cycle write request
//               read_ready/write_ready      one-cycle completion pulses (64 bit)
//               read_data                   read result, held until next read
// Revision    : 1.0 - initial release
// ============================================================================
interface scratchpad_responder_if #(
  parameter int DATA_WID = 32
);
  logic [63:0]         mem_base;
  logic                read_enable;
  logic [63:0]         read_addr;
  logic                write_enable;
  logic [63:0]         write_addr;
  logic [DATA_WID-1:0] write_data;
  logic [63:0]         read_ready;
  logic [63:0]         write_ready;
  logic [DATA_WID-1:0] read_data;

  modport master (
    output mem_base, read_enable, read_addr, write_enable, write_addr, write_data,
    input  read_ready, write_ready, read_data
  );

  modport slave (
    input  mem_base, read_enable, read_addr, write_enable, write_addr, write_data,
    output read_ready, write_ready, read_data
  );
endinterface
`default_nettype wire

// File: rtl/scratchpad_responder.sv
`default_nettype none
// ============================================================================
// Module      : scratchpad_responder
// Description : Fixed-latency memory responder for the accelerator wrapper.
//               Serves single-word reads/writes from an internal word-addressed
//               scratchpad, pulses read_ready/write_ready once per request,
//               counts accesses and flags range/overlap errors. A host port
//               preloads and inspects the scratchpad while idle.
// Ports       : clk, reset         clock, synchronous active-high reset
//               bus (slave)        kernel request/response bus
//               host_we/addr/wdata host word write (idle only)
//               host_rdata         registered read of host_addr
//               busy               state is not IDLE
//               read_count/
//               write_count        completed reads / writes (64-bit wrap)
//               err_range          sticky out-of-range/misaligned access
//               err_overlap        sticky request while busy
// Revision    : 1.0 - initial release
// ============================================================================
module scratchpad_responder #(
  parameter int ADDR_WID = 14,
  parameter int DATA_WID = 32,
  parameter int LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  scratchpad_responder_if.slave   bus,
  input  logic                    host_we,
  input  logic [ADDR_WID-1:0]     host_addr,
  input  logic [DATA_WID-1:0]     host_wdata,
  output logic [DATA_WID-1:0]     host_rdata,
  output logic                    busy,
  output logic [63:0]             read_count,
  output logic [63:0]             write_count,
  output logic                    err_range,
  output logic                    err_overlap
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEPTH = 1 << ADDR_WID;
  // WAIT lasts LATENCY-1 cycles: the count is loaded with LATENCY-2 and
  // WAIT exits once it reads zero.
  localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_write_q, op_write_d;
  logic [63:0]         op_addr_q, op_addr_d;
  logic [DATA_WID-1:0] op_data_q, op_data_d;
  logic                pend_valid_q, pend_valid_d;
  logic [63:0]         pend_addr_q, pend_addr_d;
  logic [DATA_WID-1:0] read_data_q, read_data_d;
  logic [DATA_WID-1:0] host_rdata_q, host_rdata_d;
  logic [63:0]         read_count_q, read_count_d;
  logic [63:0]         write_count_q, write_count_d;
  logic                err_range_q, err_range_d;
  logic                err_overlap_q, err_overlap_d;

  logic [DATA_WID-1:0] spad [DEPTH];
  logic                spad_we;
  logic [ADDR_WID-1:0] spad_idx;
  logic [DATA_WID-1:0] spad_wdata;

  logic                any_en;
  logic                is_idle;
  logic                start_kernel;
  logic                start_pend;
  logic                cur_write;
  logic [63:0]         cur_addr;
  logic [DATA_WID-1:0] cur_data;
  logic [63:0]         off;
  logic                addr_ok;
  logic [ADDR_WID-1:0] word_idx;

  always_comb begin
    any_en       = bus.read_enable | bus.write_enable;
    is_idle      = (state_q == ST_IDLE);
    start_kernel = is_idle & any_en;
    // A read deferred behind a simultaneous write launches straight out of
    // the write's RESP cycle.
    start_pend   = (state_q == ST_RESP) & pend_valid_q;

    // The operation that is either starting now or already in flight. When a
    // request enters RESP directly (LATENCY=1) its commit uses these values
    // before they are registered.
    if (start_kernel) begin
      cur_write = bus.write_enable;
      cur_addr  = bus.write_enable ? bus.write_addr : bus.read_addr;
      cur_data  = bus.write_data;
    end else if (start_pend) begin
      cur_write = 1'b0;
      cur_addr  = pend_addr_q;
      cur_data  = op_data_q;
    end else begin
      cur_write = op_write_q;
      cur_addr  = op_addr_q;
      cur_data  = op_data_q;
    end

    off      = cur_addr - bus.mem_base;
    addr_ok  = (cur_addr >= bus.mem_base) && (off[1:0] == 2'b00) &&
               ((off >> (ADDR_WID + 2)) == 64'd0);
    word_idx = off[ADDR_WID+1:2];

    state_d       = state_q;
    cnt_d         = cnt_q;
    op_write_d    = op_write_q;
    op_addr_d     = op_addr_q;
    op_data_d     = op_data_q;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    read_data_d   = read_data_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    err_range_d   = err_range_q;
    err_overlap_d = err_overlap_q;
    spad_we       = 1'b0;
    spad_idx      = host_addr;
    spad_wdata    = host_wdata;
    host_rdata_d  = spad[host_addr];

    if (start_kernel || start_pend) begin
      op_write_d = cur_write;
      op_addr_d  = cur_addr;
      op_data_d  = cur_data;
      cnt_d      = WAIT_LOAD;
      state_d    = (LATENCY > 1) ? ST_WAIT : ST_RESP;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ST_RESP: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end

    if (start_kernel && bus.write_enable && bus.read_enable) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = bus.read_addr;
    end else if (start_pend) begin
      pend_valid_d = 1'b0;
    end

    // Commit happens on the edge that enters RESP so read_data is valid
    // alongside the ready pulse.
    if (state_d == ST_RESP) begin
      if (cur_write) begin
        write_count_d = write_count_q + 64'd1;
        if (addr_ok) begin
          spad_we    = 1'b1;
          spad_idx   = word_idx;
          spad_wdata = cur_data;
        end
      end else begin
        read_count_d = read_count_q + 64'd1;
        read_data_d  = addr_ok ? spad[word_idx] : '0;
      end
      if (!addr_ok) begin
        err_range_d = 1'b1;
      end
    end else if (host_we && is_idle && !any_en) begin
      spad_we = 1'b1;
    end

    if (!is_idle && any_en) begin
      err_overlap_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      op_write_q    <= 1'b0;
      op_addr_q     <= 64'd0;
      op_data_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= 64'd0;
      read_data_q   <= '0;
      host_rdata_q  <= '0;
      read_count_q  <= 64'd0;
      write_count_q <= 64'd0;
      err_range_q   <= 1'b0;
      err_overlap_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_write_q    <= op_write_d;
      op_addr_q     <= op_addr_d;
      op_data_q     <= op_data_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      read_data_q   <= read_data_d;
      host_rdata_q  <= host_rdata_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      err_range_q   <= err_range_d;
      err_overlap_q <= err_overlap_d;
    end
  end

  // Contents survive reset; reset only blocks a commit in that cycle.
  always_ff @(posedge clk) begin
    if (!reset && spad_we) begin
      spad[spad_idx] <= spad_wdata;
    end
  end

  assign bus.read_ready  = {63'd0, (state_q == ST_RESP) & ~op_write_q};
  assign bus.write_ready = {63'd0, (state_q == ST_RESP) &  op_write_q};
  assign bus.read_data   = read_data_q;
  assign host_rdata      = host_rdata_q;
  assign busy            = ~is_idle;
  assign read_count      = read_count_q;
  assign write_count     = write_count_q;
  assign err_range       = err_range_q;
  assign err_overlap     = err_overlap_q;

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scratchpad_responder
// Description : Directed self-checking bench for scratchpad_responder with
//               LATENCY=2 and mem_base=0x1000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scratchpad_responder;

  logic        clk;
  logic        reset;
  logic        host_we;
  logic [13:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        busy;
  logic [63:0] read_count;
  logic [63:0] write_count;
  logic        err_range;
  logic        err_overlap;

  int n_total;
  int n_bad;

  scratchpad_responder_if #(.DATA_WID(32)) bus ();

  scratchpad_responder #(
    .ADDR_WID (14),
    .DATA_WID (32),
    .LATENCY  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .busy        (busy),
    .read_count  (read_count),
    .write_count (write_count),
    .err_range   (err_range),
    .err_overlap (err_overlap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [13:0] a, input logic [31:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_peek(input string tag, input logic [13:0] a, input logic [31:0] exp);
    host_addr = a;
    tick();
    check(tag, {32'd0, host_rdata}, {32'd0, exp});
  endtask

  // Single read with LATENCY=2: ready low one cycle after the enable, high the next.
  task automatic do_read(input string tag, input logic [63:0] a, input logic [31:0] exp);
    bus.read_enable = 1'b1; bus.read_addr = a;
    tick();
    bus.read_enable = 1'b0;
    check({tag, "_early"}, bus.read_ready, 64'd0);
    tick();
    check({tag, "_rdy"}, bus.read_ready, 64'd1);
    check({tag, "_data"}, {32'd0, bus.read_data}, {32'd0, exp});
    tick();
    check({tag, "_rdy_drop"}, bus.read_ready, 64'd0);
  endtask

  task automatic do_write(input string tag, input logic [63:0] a, input logic [31:0] d);
    bus.write_enable = 1'b1; bus.write_addr = a; bus.write_data = d;
    tick();
    bus.write_enable = 1'b0;
    check({tag, "_early"}, bus.write_ready, 64'd0);
    tick();
    check({tag, "_rdy"}, bus.write_ready, 64'd1);
    tick();
    check({tag, "_rdy_drop"}, bus.write_ready, 64'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    host_we = 1'b0; host_addr = 14'd0; host_wdata = 32'd0;
    bus.mem_base = 64'h1000;
    bus.read_enable = 1'b0; bus.read_addr = 64'd0;
    bus.write_enable = 1'b0; bus.write_addr = 64'd0; bus.write_data = 32'd0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_read_ready", bus.read_ready, 64'd0);
    check("rst_write_ready", bus.write_ready, 64'd0);
    check("rst_read_data", {32'd0, bus.read_data}, 64'd0);
    check("rst_host_rdata", {32'd0, host_rdata}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rcount", read_count, 64'd0);
    check("rst_wcount", write_count, 64'd0);
    check("rst_errs", {62'd0, err_range, err_overlap}, 64'd0);

    host_write(14'd5, 32'h1234);
    host_write(14'd0, 32'h5555);
    host_peek("host_w5", 14'd5, 32'h1234);

    // Basic read of word 5.
    do_read("rd_w5", 64'h1014, 32'h1234);
    check("rd_w5_rcount", read_count, 64'd1);
    check("rd_w5_idle", {63'd0, busy}, 64'd0);

    // Write then read back, read issued in the cycle after write_ready.
    bus.write_enable = 1'b1; bus.write_addr = 64'h1008; bus.write_data = 32'hCAFE;
    tick();
    bus.write_enable = 1'b0;
    check("wr_busy", {63'd0, busy}, 64'd1);
    check("wr_early", bus.write_ready, 64'd0);
    tick();
    check("wr_rdy", bus.write_ready, 64'd1);
    check("wr_wcount", write_count, 64'd1);
    tick();
    check("wr_rdy_drop", bus.write_ready, 64'd0);
    do_read("rd_back", 64'h1008, 32'hCAFE);
    check("rd_back_rcount", read_count, 64'd2);
    check("rd_back_ovl", {63'd0, err_overlap}, 64'd0);

    // Out-of-range above the window: zero data rather than an aliased word.
    do_read("rd_oor", 64'h1000 + 64'h10000, 32'h0);
    check("rd_oor_err", {63'd0, err_range}, 64'd1);

    // Below base, then misaligned write which must be dropped.
    do_read("rd_below", 64'h0FFC, 32'h0);
    do_write("wr_mis", 64'h1002, 32'hDEAD);
    check("wr_mis_wcount", write_count, 64'd2);
    host_peek("wr_mis_w0", 14'd0, 32'h5555);

    // Simultaneous write and read of the same word: write first, then read.
    bus.write_enable = 1'b1; bus.write_addr = 64'h1000; bus.write_data = 32'h77;
    bus.read_enable  = 1'b1; bus.read_addr  = 64'h1000;
    tick();
    bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    check("sim_t1_wr", bus.write_ready, 64'd0);
    tick();
    check("sim_t2_wr", bus.write_ready, 64'd1);
    check("sim_t2_rd", bus.read_ready, 64'd0);
    tick();
    check("sim_t3_busy", {63'd0, busy}, 64'd1);
    check("sim_t3_rdy", bus.read_ready | bus.write_ready, 64'd0);
    tick();
    check("sim_t4_rd", bus.read_ready, 64'd1);
    check("sim_t4_wr", bus.write_ready, 64'd0);
    check("sim_t4_data", {32'd0, bus.read_data}, 64'h77);
    tick();
    check("sim_t5_idle", {63'd0, busy}, 64'd0);
    check("sim_ovl", {63'd0, err_overlap}, 64'd0);
    check("sim_rcount", read_count, 64'd5);
    check("sim_wcount", write_count, 64'd3);

    // Enable while busy is ignored and flagged.
    bus.read_enable = 1'b1; bus.read_addr = 64'h1014;
    tick();
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b1; bus.write_addr = 64'h1014; bus.write_data = 32'hBAD;
    tick();
    bus.write_enable = 1'b0;
    check("ovl_rd_rdy", bus.read_ready, 64'd1);
    check("ovl_wr_rdy", bus.write_ready, 64'd0);
    tick();
    check("ovl_t3_rdy", bus.read_ready | bus.write_ready, 64'd0);
    tick();
    check("ovl_t4_rdy", bus.read_ready | bus.write_ready, 64'd0);
    check("ovl_flag", {63'd0, err_overlap}, 64'd1);
    check("ovl_wcount", write_count, 64'd3);
    host_peek("ovl_w5", 14'd5, 32'h1234);

    // Reset in the cycle after a write enable aborts it.
    bus.write_enable = 1'b1; bus.write_addr = 64'h1014; bus.write_data = 32'h1111;
    tick();
    bus.write_enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_wr_rdy", bus.write_ready, 64'd0);
    check("rst2_busy", {63'd0, busy}, 64'd0);
    check("rst2_counts", read_count | write_count, 64'd0);
    check("rst2_errs", {62'd0, err_range, err_overlap}, 64'd0);
    check("rst2_rdata", {32'd0, bus.read_data}, 64'd0);
    check("rst2_hrdata", {32'd0, host_rdata}, 64'd0);
    tick();
    check("rst2_wr_rdy_late", bus.write_ready, 64'd0);
    host_peek("rst2_w5", 14'd5, 32'h1234);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scratchpad_responder.md
# scratchpad_responder

Memory-side responder placed directly downstream of the accelerator wrapper kernel. It services the wrapper's single-word read and write requests (byte addresses, enable pulses) from an internal word-addressed scratchpad with a fixed, parameterised latency. It answers with a one-cycle `read_ready`/`write_ready` pulse, and it counts accesses and protocol errors for the bench. A host port preloads and inspects the scratchpad while the responder is idle.

## Interface
Parameters:
- `ADDR_WID`, default 14: scratchpad word-index width; depth is 2^ADDR_WID words.
- `DATA_WID`, default 32: word width.
- `LATENCY`, default 2: cycles from accepted enable to ready pulse; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_base`  in  64  byte address of word 0; held static during operation.
- `read_enable`  in  1  one-cycle read request pulse from kernel.
- `read_addr`  in  64  read byte address, sampled with `read_enable`.
- `write_enable`  in  1  one-cycle write request pulse.
- `write_addr`  in  64  write byte address, sampled with `write_enable`.
- `write_data`  in  DATA_WID  write data, sampled with `write_enable`.
- `read_ready`  out  64  value 1 for exactly one cycle when read data is valid, else 0.
- `write_ready`  out  64  value 1 for exactly one cycle when a write has committed, else 0.
- `read_data`  out  DATA_WID  read result; held until the next read completes.
- `host_we`  in  1  host write strobe.
- `host_addr`  in  ADDR_WID  host word index.
- `host_wdata`  in  DATA_WID  host write data.
- `host_rdata`  out  DATA_WID  word at `host_addr`, registered one cycle.
- `busy`  out  1  1 whenever state is not IDLE.
- `read_count`, `write_count`  out  64  completed reads and writes.
- `err_range`  out  1  sticky: out-of-range or misaligned access occurred.
- `err_overlap`  out  1  sticky: an enable arrived while busy.

## Operation
- States:
  - IDLE: accepts requests.
  - WAIT: loaded countdown; entered only when `LATENCY`>1.
  - RESP: ready-pulse cycle.
  - Transitions: IDLE→(WAIT|RESP) on an enable; WAIT→RESP when the count hits 0; RESP→IDLE always.
- Address decode:
  - off = addr − mem_base (64-bit).
  - The access is valid iff addr ≥ mem_base, off[1:0]=0, and off>>2 < 2^ADDR_WID.
  - Word index = off[ADDR_WID+1:2].
- Read: `read_data` is loaded with scratchpad[index] at the RESP edge, or 0 if invalid.
- Write: the scratchpad is updated at the RESP edge if valid; if invalid, the write is dropped.
- Any invalid access sets `err_range`. The ready pulse is still issued, so the kernel never hangs.
- Simultaneous `read_enable` and `write_enable` in IDLE:
  - The write is served first. The read address is latched into a one-entry pending slot.
  - After the write's RESP, the pending read starts immediately with a full `LATENCY`, without returning to IDLE.
  - `busy` stays 1 throughout.
- Enable while busy, with the pending slot empty or in use:
  - The request is ignored and `err_overlap` is set.
  - The one exception is the simultaneous case above.
- Counters increment in the RESP cycle: `read_count` on reads, `write_count` on writes (valid or not). Arithmetic is 64-bit wrapping.
- Host port:
  - `host_we` is honoured only when `busy`=0 and no enable is present that cycle; otherwise it is ignored.
  - `host_rdata` is always a registered read of `host_addr`.

## Timing
- Enable sampled at edge T in IDLE → ready is 1 during cycle T+LATENCY, for exactly one cycle.
- The write is visible to any read accepted at T+LATENCY+1 or later.
- The next enable is accepted at the earliest at T+LATENCY+1. This matches the kernel re-issuing in the cycle after ready.
- Back-to-back simultaneous pair: write ready at T+LATENCY, read ready at T+2·LATENCY.
- Reset values:
  - `read_ready`, `write_ready`, `read_data`, `host_rdata` = 0; `busy` = 0; counters = 0; error flags = 0.
  - State is IDLE and the pending slot is empty.
- Reset mid-operation aborts the request: no ready pulse is issued and no write commits. Scratchpad contents are not cleared.

## Test plan
- `LATENCY`=2, mem_base=0x1000: host preload word 5=0x1234; read_enable with read_addr=0x1014 at T → read_ready=1 only at T+2, read_data=0x1234, read_count=1.
- Write 0xCAFE to 0x1008, then read 0x1008 issued one cycle after write_ready → write_ready at T+2, read_data=0xCAFE; write_count=1, read_count=1.
- Read 0x0FFC, then write to 0x1002 → both get ready pulses; read_data=0, err_range=1, scratchpad unchanged (verified via host_rdata).
- Simultaneous write 0x77 to 0x1000 and read of 0x1000 at T → write_ready at T+2, read_ready at T+4 with data 0x77; err_overlap=0.
- Enable at T+1 while busy → ignored, err_overlap=1, only one ready pulse. Separately, reset at T+1 of a write → no write_ready, word unchanged, all outputs 0.
